// File: rtl/int_res_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// int_res_stream_reader_pkg
// Shared types and defaults for the intermediate-results memory and its
// streaming read initiator.
//   IntResAddr_t      word address into the intermediate-results memory
//   DataWidth_t       single- or double-word access
//   FxFormatIntRes_t  fixed-point format tag forwarded to the memory
//   CompFx_t          signed compute word returned by the memory
//   StreamRdState_t   control states of the stream reader
// -----------------------------------------------------------------------------
package int_res_stream_reader_pkg;

    localparam int INT_RES_ADDR_W = 10;
    localparam int COMP_FX_W      = 16;

    typedef logic        [INT_RES_ADDR_W-1:0] IntResAddr_t;
    typedef logic signed [COMP_FX_W-1:0]      CompFx_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic [1:0] {
        FX_Q8_8  = 2'd0,
        FX_Q4_12 = 2'd1,
        FX_Q12_4 = 2'd2,
        FX_Q16_0 = 2'd3
    } FxFormatIntRes_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } StreamRdState_t;

    localparam int INT_RES_RD_LATENCY    = 2;
    localparam int INT_RES_RD_FIFO_DEPTH = 4;

    // Double-width words occupy two consecutive addresses.
    function automatic IntResAddr_t addr_stride(input DataWidth_t w);
        return (w == DOUBLE_WIDTH) ? IntResAddr_t'(2) : IntResAddr_t'(1);
    endfunction

endpackage

// File: rtl/int_res_stream_reader_sync_fifo.sv
// -----------------------------------------------------------------------------
// int_res_stream_reader_sync_fifo
// Synchronous first-word fall-through FIFO with an occupancy count.
//   clk_i, rst_i  clock and synchronous active-high reset (control only)
//   push_i/data_i write side; a push while full is accepted only with a pop
//   pop_i         consume the head word (ignored when empty)
//   data_o        head word, valid whenever empty_o is low
//   empty_o       no words stored
//   count_o       number of words stored (0..DEPTH)
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module int_res_stream_reader_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot freed by a same-cycle pop takes the new word.
    assign do_push = push_i && (!full || pop_i);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/int_res_stream_reader.sv
// -----------------------------------------------------------------------------
// int_res_stream_reader
// Walks a contiguous address range of the intermediate-results memory and
// streams the returned words out on a valid/ready interface. Reads are issued
// only while buffer credit exists, so the fixed read latency never loses data
// under back-pressure.
//   clk, rst_n        clock; rst_n is a synchronous ACTIVE-HIGH reset
//   start             begin a transfer (ignored while busy or in DONE)
//   base_addr, length, data_width, format   transfer descriptor, sampled on start
//   mem_rd_en/addr/width/format  read request to the memory
//   mem_rd_data       read data, READ_LATENCY cycles after mem_rd_en
//   out_valid/out_ready/out_data/out_last  output stream
//   busy              transfer in progress
//   done              one-cycle pulse after the final word is accepted
// READ_LATENCY >= 1; FIFO_DEPTH >= READ_LATENCY+1 and a power of two.
// -----------------------------------------------------------------------------
module int_res_stream_reader
    import int_res_stream_reader_pkg::*;
#(
    parameter int READ_LATENCY = INT_RES_RD_LATENCY,
    parameter int FIFO_DEPTH   = INT_RES_RD_FIFO_DEPTH,
    parameter int LEN_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  IntResAddr_t      base_addr,
    input  logic [LEN_W-1:0] length,
    input  DataWidth_t       data_width,
    input  FxFormatIntRes_t  format,
    output logic             mem_rd_en,
    output IntResAddr_t      mem_rd_addr,
    output DataWidth_t       mem_rd_width,
    output FxFormatIntRes_t  mem_rd_format,
    input  CompFx_t          mem_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output CompFx_t          out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    StreamRdState_t    state_q;
    logic              en_q;
    IntResAddr_t       addr_q;
    DataWidth_t        width_q;
    FxFormatIntRes_t   fmt_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  remain_q;   // requests still to issue after the current one
    logic [LEN_W-1:0]  out_cnt_q;  // words accepted so far
    logic              busy_q;
    logic              done_q;

    logic [READ_LATENCY-1:0] tag_q;
    logic [CNT_W-1:0]        inflight_q;
    logic [CNT_W-1:0]        inflight_d;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    CompFx_t                 fifo_data;
    logic                    land;
    logic                    pop;
    logic [SUM_W-1:0]        occ_next;
    logic                    credit;

    assign land = tag_q[READ_LATENCY-1];
    assign pop  = !fifo_empty && out_ready;

    always_comb begin
        inflight_d = inflight_q;
        if (en_q && !land)      inflight_d = inflight_q + CNT_W'(1);
        else if (!en_q && land) inflight_d = inflight_q - CNT_W'(1);
    end

    // Reads in flight plus buffered words as seen next cycle; a new request
    // registered now is issued next cycle and must find a reserved slot.
    assign occ_next = SUM_W'(inflight_d) + SUM_W'(fifo_count) + SUM_W'(land) - SUM_W'(pop);
    assign credit   = (occ_next < SUM_W'(FIFO_DEPTH));

    // ---- issue tag pipeline: marks which memory-data cycles carry our reads
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            tag_q[0] <= en_q;
            for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            inflight_q <= inflight_d;
        end
    end

    // ---- control FSM with registered request and status outputs
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            addr_q    <= '0;
            width_q   <= SINGLE_WIDTH;
            fmt_q     <= FX_Q8_8;
            len_q     <= '0;
            remain_q  <= '0;
            out_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            if (pop) out_cnt_q <= out_cnt_q + LEN_W'(1);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            // The FIFO is empty here, so the first read needs no credit check.
                            state_q   <= ISSUE;
                            busy_q    <= 1'b1;
                            en_q      <= 1'b1;
                            addr_q    <= base_addr;
                            width_q   <= data_width;
                            fmt_q     <= format;
                            len_q     <= length;
                            remain_q  <= length - LEN_W'(1);
                            out_cnt_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (remain_q == '0) begin
                        state_q <= DRAIN;
                    end else if (credit) begin
                        en_q     <= 1'b1;
                        addr_q   <= addr_q + addr_stride(width_q);
                        remain_q <= remain_q - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    // Accepting the final word implies every read has landed and drained.
                    if (pop && (out_cnt_q == len_q - LEN_W'(1))) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    int_res_stream_reader_sync_fifo #(
        .T     (CompFx_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .push_i  (land),
        .data_i  (mem_rd_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem_rd_en     = en_q;
    assign mem_rd_addr   = addr_q;
    assign mem_rd_width  = width_q;
    assign mem_rd_format = fmt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign out_valid     = !fifo_empty;
    // FIFO storage is not reset; gate the head word so the output reads 0 when idle.
    assign out_data      = out_valid ? fifo_data : '0;
    assign out_last      = out_valid && (out_cnt_q == len_q - LEN_W'(1));

endmodule

// File: tb/tb_int_res_stream_reader.sv
module tb_int_res_stream_reader;
    import int_res_stream_reader_pkg::*;

    localparam int L      = INT_RES_RD_LATENCY;
    localparam int DEPTH  = INT_RES_RD_FIFO_DEPTH;
    localparam int LEN_W  = 16;
    localparam int ADDR_N = 1 << INT_RES_ADDR_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    IntResAddr_t      base_addr;
    logic [LEN_W-1:0] length;
    DataWidth_t       data_width;
    FxFormatIntRes_t  format;
    logic             mem_rd_en;
    IntResAddr_t      mem_rd_addr;
    DataWidth_t       mem_rd_width;
    FxFormatIntRes_t  mem_rd_format;
    CompFx_t          mem_rd_data;
    logic             out_valid;
    logic             out_ready;
    CompFx_t          out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    int_res_stream_reader #(
        .READ_LATENCY (L),
        .FIFO_DEPTH   (DEPTH),
        .LEN_W        (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .data_width    (data_width),
        .format        (format),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_width  (mem_rd_width),
        .mem_rd_format (mem_rd_format),
        .mem_rd_data   (mem_rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    // Memory model: word at the requested address appears L cycles later;
    // cycles without a request return noise.
    CompFx_t mem [ADDR_N];
    CompFx_t rd_pipe [L];

    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd_en ? mem[mem_rd_addr] : CompFx_t'($urandom);
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[L-1];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero();
        chk_eq("rst_rd_en",   mem_rd_en, 0);
        chk_eq("rst_rd_addr", mem_rd_addr, 0);
        chk_eq("rst_rd_wid",  mem_rd_width, 0);
        chk_eq("rst_rd_fmt",  mem_rd_format, 0);
        chk_eq("rst_valid",   out_valid, 0);
        chk_eq("rst_data",    out_data, 0);
        chk_eq("rst_last",    out_last, 0);
        chk_eq("rst_busy",    busy, 0);
        chk_eq("rst_done",    done, 0);
    endtask

    // mode 0: always ready; 1: random ready; 2: stalled in cycles 3..12
    function automatic logic ready_for(input int mode, input int t);
        case (mode)
            1:       return ($urandom_range(0, 3) != 0);
            2:       return !(t >= 3 && t <= 12);
            default: return 1'b1;
        endcase
    endfunction

    // Runs one transfer with start in relative cycle 0 and checks every cycle
    // against the expected address sequence and memory contents.
    task automatic run_xfer(input IntResAddr_t base, input int len, input DataWidth_t w,
                            input FxFormatIntRes_t f, input int rmode, input bit timed);
        IntResAddr_t exp_addr[$];
        CompFx_t     exp_data[$];
        int          stride, rel, iss, acc, done_cyc, budget;
        bit          hold;
        CompFx_t     hold_d;
        logic        hold_l;
        stride = (w == DOUBLE_WIDTH) ? 2 : 1;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(IntResAddr_t'((int'(base) + i * stride) % ADDR_N));
            exp_data.push_back(mem[(int'(base) + i * stride) % ADDR_N]);
        end
        iss = 0; acc = 0; done_cyc = -1; hold = 0; rel = 0; budget = 40 * len + 60;
        hold_d = '0; hold_l = 1'b0;

        @(posedge clk); #1;
        start = 1'b1; base_addr = base; length = LEN_W'(len);
        data_width = w; format = f; out_ready = ready_for(rmode, 0);
        forever begin
            @(negedge clk);
            if (hold) begin
                chk_eq("hold_valid", out_valid, 1);
                chk_eq("hold_data", out_data, hold_d);
                chk_eq("hold_last", out_last, hold_l);
            end
            if (mem_rd_en) begin
                iss++;
                if (exp_addr.size() == 0) chk_eq("extra_req", 1, 0);
                else chk_eq("rd_addr", mem_rd_addr, exp_addr.pop_front());
                chk_eq("rd_width", mem_rd_width, w);
                chk_eq("rd_fmt", mem_rd_format, f);
                chk_eq("credit", (iss - acc) <= DEPTH, 1);
                if (timed) chk_eq("rd_cycle", rel, iss);
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) chk_eq("extra_word", 1, 0);
                else begin
                    chk_eq("out_data", out_data, exp_data.pop_front());
                    chk_eq("out_last", out_last, acc == len - 1);
                    if (timed) chk_eq("out_cycle", rel, 2 + L + acc);
                end
                acc++;
            end
            hold   = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            chk_eq("busy", busy, (len > 0) && (rel >= 1) && !done);
            if (done) begin
                done_cyc = rel;
                break;
            end
            if (rel >= budget) begin
                chk_eq("done_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            rel++;
            start = (rmode == 1) && (len > 0) && (rel == 2);  // must be ignored while busy
            if (start) begin
                base_addr = IntResAddr_t'(base + 7);
                length    = LEN_W'(5);
            end
            out_ready = ready_for(rmode, rel);
        end
        chk_eq("word_count", acc, len);
        chk_eq("req_count", iss, len);
        if (timed && done_cyc >= 0) chk_eq("done_cycle", done_cyc, (len == 0) ? 1 : len + L + 2);
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk_eq("done_pulse", done, 0);
        chk_eq("idle_busy", busy, 0);
        chk_eq("idle_valid", out_valid, 0);
        chk_eq("idle_rd_en", mem_rd_en, 0);
    endtask

    initial begin
        for (int i = 0; i < ADDR_N; i++) mem[i] = CompFx_t'($urandom);
        for (int i = 0; i < 4; i++) mem[10 + i] = CompFx_t'(i + 1);

        rst_n = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        data_width = SINGLE_WIDTH; format = FX_Q8_8; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        run_xfer(IntResAddr_t'(10), 4, SINGLE_WIDTH, FX_Q4_12, 0, 1);
        run_xfer(IntResAddr_t'(0), 3, DOUBLE_WIDTH, FX_Q12_4, 0, 1);
        run_xfer(IntResAddr_t'(200), 8, SINGLE_WIDTH, FX_Q16_0, 2, 0);
        run_xfer(IntResAddr_t'(5), 0, SINGLE_WIDTH, FX_Q8_8, 0, 1);
        run_xfer(IntResAddr_t'(ADDR_N - 2), 3, SINGLE_WIDTH, FX_Q8_8, 0, 1);

        // Reset in cycle 3 of a 6-word transfer, then a fresh transfer.
        @(posedge clk); #1;
        start = 1'b1; base_addr = IntResAddr_t'(100); length = LEN_W'(6);
        data_width = SINGLE_WIDTH; format = FX_Q4_12; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1 chk_outputs_zero();
        end
        rst_n = 1'b0;
        run_xfer(IntResAddr_t'(20), 2, SINGLE_WIDTH, FX_Q8_8, 0, 1);

        repeat (8) begin
            run_xfer(IntResAddr_t'($urandom), $urandom_range(1, 12),
                     DataWidth_t'($urandom_range(0, 1)),
                     FxFormatIntRes_t'($urandom_range(0, 3)), 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
